// File: rtl/control_pkg.sv
// Control encodings for the execute stage: comparator ops, results, and branch-resolve states.
package control_pkg;
    typedef enum logic [2:0] {
        CMP_BEQ  = 3'd0,
        CMP_BNE  = 3'd1,
        CMP_BLT  = 3'd2,
        CMP_BGE  = 3'd3,
        CMP_BLTU = 3'd4,
        CMP_BGEU = 3'd5
    } e_branch_operation_sel;

    typedef enum logic {
        BR_NOT_TAKEN = 1'b0,
        BR_TAKEN     = 1'b1
    } e_branch_result;

    typedef enum logic [1:0] {
        BRC_IDLE     = 2'd0,
        BRC_CMP      = 2'd1,
        BRC_REDIRECT = 2'd2,
        BRC_FLUSH    = 2'd3
    } e_brc_state;
endpackage

// File: rtl/instructions_pkg.sv
// Architectural constants shared across the core.
package instructions_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/branch_comparator.sv
// Combinational branch condition evaluator; result is forced to not-taken while disabled.
module BranchComparator
    import control_pkg::*;
#(
    parameter int DATA_W = instructions_pkg::XLEN
) (
    input  logic                  enable,
    input  e_branch_operation_sel op,
    input  logic [DATA_W-1:0]     rs1,
    input  logic [DATA_W-1:0]     rs2,
    output e_branch_result        result_masked
);
    logic           cond;
    e_branch_result result;

    always_comb begin
        cond = 1'b0;
        case (op)
            CMP_BEQ:  cond = (rs1 == rs2);
            CMP_BNE:  cond = (rs1 != rs2);
            CMP_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            CMP_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            CMP_BLTU: cond = (rs1 <  rs2);
            CMP_BGEU: cond = (rs1 >= rs2);
            default:  cond = 1'b0;
        endcase
        result        = cond ? BR_TAKEN : BR_NOT_TAKEN;
        result_masked = enable ? result : BR_NOT_TAKEN;
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: resolves one branch at a time, redirects fetch,
// holds a post-redirect flush, and keeps saturating taken/not-taken counters.
module branch_resolve_ctrl
    import control_pkg::*;
#(
    parameter int DATA_W       = instructions_pkg::XLEN,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  e_branch_operation_sel br_op,
    input  logic [DATA_W-1:0]     br_rs1,
    input  logic [DATA_W-1:0]     br_rs2,
    input  logic [DATA_W-1:0]     br_pc,
    input  logic [DATA_W-1:0]     br_imm,
    input  logic                  kill,
    output logic                  resolve_valid,
    output logic                  resolve_taken,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_W-1:0]     redirect_pc,
    output logic                  flush,
    output logic                  misalign_exc,
    output logic [DATA_W-1:0]     misalign_addr,
    input  logic                  cnt_clear,
    output logic [CNT_W-1:0]      taken_cnt,
    output logic [CNT_W-1:0]      not_taken_cnt
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    e_brc_state            state;
    e_branch_operation_sel lat_op;
    logic [DATA_W-1:0]     lat_rs1;
    logic [DATA_W-1:0]     lat_rs2;
    logic [DATA_W-1:0]     lat_pc;
    logic [DATA_W-1:0]     lat_imm;
    logic [FC_W-1:0]       flush_cnt;

    logic                  cmp_en;
    e_branch_result        cmp_res;
    logic                  taken;
    logic [DATA_W-1:0]     target;
    logic                  inc_taken;
    logic                  inc_not_taken;

    assign cmp_en        = (state == BRC_CMP);
    assign taken         = (cmp_res == BR_TAKEN);
    assign target        = lat_pc + lat_imm;
    assign inc_taken     = cmp_en && !kill && taken;
    assign inc_not_taken = cmp_en && !kill && !taken;

    BranchComparator #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .enable        (cmp_en),
        .op            (lat_op),
        .rs1           (lat_rs1),
        .rs2           (lat_rs2),
        .result_masked (cmp_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BRC_IDLE;
            br_ready       <= 1'b1;
            lat_op         <= CMP_BEQ;
            lat_rs1        <= '0;
            lat_rs2        <= '0;
            lat_pc         <= '0;
            lat_imm        <= '0;
            flush_cnt      <= '0;
            resolve_valid  <= 1'b0;
            resolve_taken  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            resolve_valid <= 1'b0;
            resolve_taken <= 1'b0;
            misalign_exc  <= 1'b0;
            // kill wins over everything, including a same-cycle redirect handshake
            if (kill) begin
                state          <= BRC_IDLE;
                br_ready       <= 1'b1;
                redirect_valid <= 1'b0;
                flush          <= 1'b0;
            end else begin
                case (state)
                    BRC_IDLE: begin
                        if (br_valid) begin
                            lat_op   <= br_op;
                            lat_rs1  <= br_rs1;
                            lat_rs2  <= br_rs2;
                            lat_pc   <= br_pc;
                            lat_imm  <= br_imm;
                            br_ready <= 1'b0;
                            state    <= BRC_CMP;
                        end
                    end
                    BRC_CMP: begin
                        resolve_valid <= 1'b1;
                        resolve_taken <= taken;
                        if (!taken) begin
                            br_ready <= 1'b1;
                            state    <= BRC_IDLE;
                        end else if (target[1:0] != 2'b00) begin
                            misalign_exc  <= 1'b1;
                            misalign_addr <= target;
                            br_ready      <= 1'b1;
                            state         <= BRC_IDLE;
                        end else begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= target;
                            flush          <= 1'b1;
                            state          <= BRC_REDIRECT;
                        end
                    end
                    BRC_REDIRECT: begin
                        if (redirect_ready) begin
                            redirect_valid <= 1'b0;
                            if (FLUSH_CYCLES == 0) begin
                                flush    <= 1'b0;
                                br_ready <= 1'b1;
                                state    <= BRC_IDLE;
                            end else begin
                                flush_cnt <= FC_W'(FLUSH_CYCLES);
                                state     <= BRC_FLUSH;
                            end
                        end
                    end
                    BRC_FLUSH: begin
                        if (flush_cnt <= FC_W'(1)) begin
                            flush    <= 1'b0;
                            br_ready <= 1'b1;
                            state    <= BRC_IDLE;
                        end else begin
                            flush_cnt <= flush_cnt - FC_W'(1);
                        end
                    end
                    default: begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                        br_ready       <= 1'b1;
                        state          <= BRC_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (cnt_clear) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else begin
            if (inc_taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (inc_not_taken && (not_taken_cnt != '1)) begin
                not_taken_cnt <= not_taken_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, kill/counter/reset corners, random branches.
module tb_branch_resolve_ctrl;
    import control_pkg::*;

    localparam int DW      = 32;
    localparam int FLUSH_N = 2;
    localparam int CW      = 6;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct {
        e_branch_operation_sel op;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
        logic [31:0]           pc;
        logic [31:0]           imm;
        int                    stall;
        bit                    exp_taken;
        logic [31:0]           exp_target;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  br_valid;
    logic                  br_ready;
    e_branch_operation_sel br_op;
    logic [DW-1:0]         br_rs1, br_rs2, br_pc, br_imm;
    logic                  kill;
    logic                  resolve_valid, resolve_taken;
    logic                  redirect_valid, redirect_ready;
    logic [DW-1:0]         redirect_pc;
    logic                  flush;
    logic                  misalign_exc;
    logic [DW-1:0]         misalign_addr;
    logic                  cnt_clear;
    logic [CW-1:0]         taken_cnt, not_taken_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int m_taken = 0;
    int m_nt    = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .DATA_W       (DW),
        .FLUSH_CYCLES (FLUSH_N),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_op          (br_op),
        .br_rs1         (br_rs1),
        .br_rs2         (br_rs2),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .kill           (kill),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .misalign_exc   (misalign_exc),
        .misalign_addr  (misalign_addr),
        .cnt_clear      (cnt_clear),
        .taken_cnt      (taken_cnt),
        .not_taken_cnt  (not_taken_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit ref_taken(input e_branch_operation_sel op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            CMP_BEQ:  return a == b;
            CMP_BNE:  return a != b;
            CMP_BLT:  return sa < sb;
            CMP_BGE:  return sa >= sb;
            CMP_BLTU: return {1'b0, a} < {1'b0, b};
            CMP_BGEU: return {1'b0, a} >= {1'b0, b};
            default:  return 1'b0;
        endcase
    endfunction

    task automatic offer(input vec_t v);
        br_valid = 1'b1;
        br_op    = v.op;
        br_rs1   = v.rs1;
        br_rs2   = v.rs2;
        br_pc    = v.pc;
        br_imm   = v.imm;
        @(negedge clk);
        br_valid = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(m_taken));
        check({tag, "_nt_cnt"}, 32'(not_taken_cnt), 32'(m_nt));
    endtask

    // Full cycle-accurate walk of one branch; expected behaviour comes from v.
    task automatic apply(input vec_t v, input string tag);
        bit mis;
        mis = v.exp_taken && (v.exp_target[1:0] != 2'b00);
        check({tag, "_ready_idle"}, 32'(br_ready), 1);
        offer(v);
        check({tag, "_ready_cmp"}, 32'(br_ready), 0);
        check({tag, "_resolve_early"}, 32'(resolve_valid), 0);
        @(negedge clk);
        if (v.exp_taken) m_taken = sat_inc(m_taken);
        else             m_nt    = sat_inc(m_nt);
        check({tag, "_resolve_valid"}, 32'(resolve_valid), 1);
        check({tag, "_resolve_taken"}, 32'(resolve_taken), 32'(v.exp_taken));
        check({tag, "_misalign_exc"}, 32'(misalign_exc), 32'(mis));
        check_counters(tag);
        if (mis) check({tag, "_misalign_addr"}, misalign_addr, v.exp_target);
        if (!v.exp_taken || mis) begin
            check({tag, "_ready_back"}, 32'(br_ready), 1);
            check({tag, "_no_redirect"}, 32'(redirect_valid), 0);
            check({tag, "_no_flush"}, 32'(flush), 0);
        end else begin
            check({tag, "_redirect_valid"}, 32'(redirect_valid), 1);
            check({tag, "_redirect_pc"}, redirect_pc, v.exp_target);
            check({tag, "_flush"}, 32'(flush), 1);
            check({tag, "_ready_redir"}, 32'(br_ready), 0);
            for (int i = 0; i < v.stall; i++) begin
                redirect_ready = 1'b0;
                @(negedge clk);
                check({tag, "_stall_valid"}, 32'(redirect_valid), 1);
                check({tag, "_stall_pc"}, redirect_pc, v.exp_target);
                check({tag, "_stall_flush"}, 32'(flush), 1);
                check({tag, "_stall_resolve"}, 32'(resolve_valid), 0);
            end
            redirect_ready = 1'b1;
            @(negedge clk);
            redirect_ready = 1'b0;
            for (int i = 0; i < FLUSH_N; i++) begin
                check({tag, "_flush_hold"}, 32'(flush), 1);
                check({tag, "_flush_no_redir"}, 32'(redirect_valid), 0);
                check({tag, "_flush_ready"}, 32'(br_ready), 0);
                @(negedge clk);
            end
            check({tag, "_flush_done"}, 32'(flush), 0);
            check({tag, "_ready_after"}, 32'(br_ready), 1);
        end
    endtask

    vec_t vecs[10];
    vec_t v;

    initial begin
        vecs[0] = '{CMP_BEQ,  32'd5,         32'd6,          32'h100,      32'h10,       0, 1'b0, 32'h0};
        vecs[1] = '{CMP_BGE,  32'd0,         32'd0,          32'h100,      32'hFFFFFFF0, 3, 1'b1, 32'hF0};
        vecs[2] = '{CMP_BLT,  32'hFFFFFFCE,  32'd51,         32'h200,      32'h8,        0, 1'b1, 32'h208};
        vecs[3] = '{CMP_BLTU, 32'hFFFFFFCE,  32'd51,         32'h200,      32'h8,        0, 1'b0, 32'h0};
        vecs[4] = '{CMP_BEQ,  32'd7,         32'd7,          32'hFFFFFFFC, 32'h6,        0, 1'b1, 32'h2};
        vecs[5] = '{CMP_BEQ,  32'd7,         32'd7,          32'hFFFFFFFC, 32'h8,        1, 1'b1, 32'h4};
        vecs[6] = '{CMP_BNE,  32'd1,         32'd2,          32'h40,       32'h20,       0, 1'b1, 32'h60};
        vecs[7] = '{CMP_BGEU, 32'd3,         32'hFFFFFFFF,   32'h80,       32'h4,        0, 1'b0, 32'h0};
        vecs[8] = '{CMP_BGE,  32'h80000000,  32'd1,          32'h80,       32'h4,        0, 1'b0, 32'h0};
        vecs[9] = '{CMP_BGEU, 32'h80000000,  32'd1,          32'h300,      32'hFFFFFF00, 2, 1'b1, 32'h200};

        rst = 1'b1; br_valid = 1'b0; br_op = CMP_BEQ;
        br_rs1 = '0; br_rs2 = '0; br_pc = '0; br_imm = '0;
        kill = 1'b0; redirect_ready = 1'b0; cnt_clear = 1'b0;
        @(negedge clk);
        check("rst_br_ready", 32'(br_ready), 1);
        check("rst_resolve", 32'(resolve_valid), 0);
        check("rst_redirect", 32'(redirect_valid), 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_misalign", 32'(misalign_exc), 0);
        check_counters("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("tab%0d", i));

        // kill during CMP: no resolve, counters frozen
        offer(vecs[6]);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("killcmp_resolve", 32'(resolve_valid), 0);
        check("killcmp_redirect", 32'(redirect_valid), 0);
        check("killcmp_ready", 32'(br_ready), 1);
        check_counters("killcmp");

        // kill in REDIRECT together with redirect_ready
        offer(vecs[6]);
        @(negedge clk);
        m_taken = sat_inc(m_taken);
        check("killred_pre_valid", 32'(redirect_valid), 1);
        kill = 1'b1;
        redirect_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        redirect_ready = 1'b0;
        check("killred_valid", 32'(redirect_valid), 0);
        check("killred_flush", 32'(flush), 0);
        check("killred_ready", 32'(br_ready), 1);
        @(negedge clk);
        check("killred_flush_later", 32'(flush), 0);
        check_counters("killred");

        // kill in IDLE blocks acceptance
        kill = 1'b1;
        offer(vecs[0]);
        kill = 1'b0;
        check("killidle_ready", 32'(br_ready), 1);
        @(negedge clk);
        check("killidle_no_resolve", 32'(resolve_valid), 0);

        // cnt_clear beats a same-cycle increment
        offer(vecs[0]);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        m_taken = 0;
        m_nt    = 0;
        check("clr_resolve", 32'(resolve_valid), 1);
        check_counters("clr");

        // taken counter saturation using misaligned taken branches
        v = '{CMP_BEQ, 32'd0, 32'd0, 32'h0, 32'h2, 0, 1'b1, 32'h2};
        for (int i = 0; i < CMAX + 4; i++) apply(v, "sat");
        check("sat_taken_cnt", 32'(taken_cnt), CMAX);

        for (int i = 0; i < 200; i++) begin
            v.op    = e_branch_operation_sel'($urandom_range(0, 5));
            v.rs1   = $urandom;
            v.rs2   = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
            v.pc    = $urandom & 32'hFFFF_FFFC;
            v.imm   = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            v.stall = $urandom_range(0, 3);
            v.exp_taken  = ref_taken(v.op, v.rs1, v.rs2);
            v.exp_target = v.pc + v.imm;
            apply(v, "rnd");
        end

        // async reset while a redirect is pending
        offer(vecs[6]);
        @(negedge clk);
        check("rstred_pre_valid", 32'(redirect_valid), 1);
        rst = 1'b1;
        #1;
        m_taken = 0;
        m_nt    = 0;
        check("rstred_valid", 32'(redirect_valid), 0);
        check("rstred_flush", 32'(flush), 0);
        check("rstred_ready", 32'(br_ready), 1);
        check("rstred_resolve", 32'(resolve_valid), 0);
        check_counters("rstred");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
